// File: rtl/conv_stim_gen_if.sv
// Output bundle of conv_stim_gen: one coded frame plus its info bits, frame counter and
// a valid/ready handshake.
//   out_valid  master->slave  para_out/test_data/frame_cnt hold a complete frame
//   out_ready  slave->master  consumer accepts the frame on an edge where out_valid=1
//   para_out   master->slave  coded frame, bit 2i = c0 of symbol i, bit 2i+1 = c1
//   test_data  master->slave  info bits of the frame, bit i = symbol i
//   frame_cnt  master->slave  frames loaded into the output register, wraps at 2^16
interface conv_stim_gen_if #(
  parameter int unsigned FRAME_SYMS = 8
);
  logic                      out_valid;
  logic                      out_ready;
  logic [2*FRAME_SYMS-1:0]   para_out;
  logic [FRAME_SYMS-1:0]     test_data;
  logic [15:0]               frame_cnt;

  modport master (
    output out_valid,
    output para_out,
    output test_data,
    output frame_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  para_out,
    input  test_data,
    input  frame_cnt,
    output out_ready
  );
endinterface

// File: rtl/conv_stim_gen.sv
// Rate-1/2 convolutional-code stimulus source.
// Info bit (LFSR or external) -> constraint-length-K encoder -> frame packer -> valid/ready.
//   clk      posedge clock
//   rst      asynchronous active-low reset
//   enable   1: advance one info bit per cycle unless the completing step is stalled
//   ext_sel  1: info bit from ext_bit, 0: info bit from lfsr[0]
//   ext_bit  external info bit, sampled on a step
//   out_if   master side of the frame handshake (see conv_stim_gen_if)
module conv_stim_gen #(
  parameter int unsigned    FRAME_SYMS = 8,
  parameter int unsigned    K          = 3,
  parameter logic [K-1:0]   G0         = 3'b111,
  parameter logic [K-1:0]   G1         = 3'b101,
  parameter logic [15:0]    SEED       = 16'hACE1,
  parameter bit             TAIL_EN    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ext_sel,
  input  logic             ext_bit,
  conv_stim_gen_if.master  out_if
);

  localparam int unsigned SYM_W = $clog2(FRAME_SYMS);
  localparam logic [SYM_W-1:0] LAST_SYM   = SYM_W'(FRAME_SYMS - 1);
  localparam logic [SYM_W-1:0] TAIL_START = SYM_W'(FRAME_SYMS - (K - 1));

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  out_state_t                state, state_nxt;

  logic [15:0]               lfsr, lfsr_nxt;
  logic [K-2:0]              sr;
  logic [SYM_W-1:0]          sym, sym_nxt;
  logic [2*FRAME_SYMS-1:0]   acc, acc_nxt;
  logic [FRAME_SYMS-1:0]     dacc, dacc_nxt;
  logic [2*FRAME_SYMS-1:0]   para_q;
  logic [FRAME_SYMS-1:0]     data_q;
  logic [15:0]               cnt_q;

  logic                      last, stall, step, tail, lfsr_src, info, c0, c1;
  logic [K-1:0]              w;

  // ---------------------------------------------------------------------------
  // Step decode and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    last     = (sym == LAST_SYM);
    // Only the frame-completing step can collide with an unread output frame.
    stall    = last && (state == OUT_FULL) && !out_if.out_ready;
    step     = enable && !stall;
    tail     = TAIL_EN && (sym >= TAIL_START);
    lfsr_src = !tail && !ext_sel;

    if (tail)         info = 1'b0;
    else if (ext_sel) info = ext_bit;
    else              info = lfsr[0];

    w  = {info, sr};
    c0 = ^(w & G0);
    c1 = ^(w & G1);

    lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    sym_nxt  = last ? '0 : sym + 1'b1;

    // Merge the current symbol so the completing step can load the output
    // register in the same edge without a bubble.
    acc_nxt  = acc;
    dacc_nxt = dacc;
    for (int unsigned i = 0; i < FRAME_SYMS; i++) begin
      if (sym == SYM_W'(i)) begin
        acc_nxt[2*i +: 2] = {c1, c0};
        dacc_nxt[i]       = info;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output frame register state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      OUT_EMPTY: if (step && last) state_nxt = OUT_FULL;
      OUT_FULL: begin
        // A completing step on the consume edge refills immediately.
        if (step && last)         state_nxt = OUT_FULL;
        else if (out_if.out_ready) state_nxt = OUT_EMPTY;
      end
      default: state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OUT_EMPTY;
    else      state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Generator state, packer buffers and output frame
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr   <= SEED;
      sr     <= '0;
      sym    <= '0;
      acc    <= '0;
      dacc   <= '0;
      para_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else if (step) begin
      if (lfsr_src) lfsr <= lfsr_nxt;
      sr   <= w[K-1:1];
      sym  <= sym_nxt;
      acc  <= acc_nxt;
      dacc <= dacc_nxt;
      if (last) begin
        para_q <= acc_nxt;
        data_q <= dacc_nxt;
        cnt_q  <= cnt_q + 16'd1;
      end
    end
  end

  assign out_if.out_valid = (state == OUT_FULL);
  assign out_if.para_out  = para_q;
  assign out_if.test_data = data_q;
  assign out_if.frame_cnt = cnt_q;

endmodule
